// File: rtl/cnn_layer_accel_weight_loader_if.sv
// Purpose : groups the job, weight-stream and table-configuration signals of the weight loader.
// Latency : n/a (signal bundle only).
// Backpressure: stream uses valid/ready; job side uses job_ready; the table side has no backpressure.
// Ports   : job_start/job_num_kernels/job_ready/job_done (job side),
//           wht_stream_data/valid/ready (DMA side),
//           config_mode/job_accept/kernel_config_valid/num_kernels/wht_config_wren/wht_config_data (table side).
// Modports: master = the loader, slave = the surrounding environment.
interface cnn_layer_accel_weight_loader_if #(
  parameter int C_WEIGHT_WIDTH     = 16,
  parameter int C_WEIGHTS_PER_BEAT = 4
);
  logic                                         job_start;
  logic [6:0]                                   job_num_kernels;
  logic                                         job_ready;
  logic                                         job_done;
  logic [C_WEIGHT_WIDTH*C_WEIGHTS_PER_BEAT-1:0] wht_stream_data;
  logic                                         wht_stream_valid;
  logic                                         wht_stream_ready;
  logic                                         config_mode;
  logic                                         job_accept;
  logic                                         kernel_config_valid;
  logic [15:0]                                  num_kernels;
  logic                                         wht_config_wren;
  logic [C_WEIGHT_WIDTH-1:0]                    wht_config_data;

  modport master (
    input  job_start, job_num_kernels, wht_stream_data, wht_stream_valid,
    output job_ready, job_done, wht_stream_ready, config_mode, job_accept,
           kernel_config_valid, num_kernels, wht_config_wren, wht_config_data
  );

  modport slave (
    output job_start, job_num_kernels, wht_stream_data, wht_stream_valid,
    input  job_ready, job_done, wht_stream_ready, config_mode, job_accept,
           kernel_config_valid, num_kernels, wht_config_wren, wht_config_data
  );
endinterface

// File: rtl/cnn_layer_accel_weight_loader.sv
// Purpose : unpacks a packed weight stream and writes it into the weight table as 9-cycle kernel bursts.
// Latency : job_start at t -> CFG t+1, first write t+5, last write t+4+9K, job_done t+6+9K (stream never stalling).
// Backpressure: wht_stream_ready drops when the unpack FIFO cannot take a full beat; bursts never stall once started.
// Ports   : clk, rst (sync, active-high), bus (master modport: job, stream and table-config signals).
module cnn_layer_accel_weight_loader #(
  parameter int C_WEIGHT_WIDTH     = 16,
  parameter int C_WEIGHTS_PER_BEAT = 4,
  parameter int C_KERNEL_SIZE      = 9,
  parameter int C_MAX_KERNELS      = 64,
  parameter int C_BUF_DEPTH        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  cnn_layer_accel_weight_loader_if.master bus
);
  localparam int AW  = $clog2(C_BUF_DEPTH);
  localparam int OW  = $clog2(C_BUF_DEPTH + 1);
  localparam int WLW = $clog2(C_KERNEL_SIZE * C_MAX_KERNELS + 1);
  localparam int BLW = $clog2((C_KERNEL_SIZE * C_MAX_KERNELS + C_WEIGHTS_PER_BEAT - 1) / C_WEIGHTS_PER_BEAT + 1);
  localparam int KW  = $clog2(C_MAX_KERNELS + 1);
  localparam int BCW = $clog2(C_KERNEL_SIZE);
  localparam int PW  = $clog2(C_WEIGHTS_PER_BEAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_LOAD, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [KW-1:0]             kernels_left;
  logic [WLW-1:0]            weights_left;
  logic [BLW-1:0]            beats_left;
  logic [15:0]               num_kernels_q;
  logic                      burst_act;
  logic [BCW-1:0]            burst_cnt;
  logic [AW-1:0]             wp, rp;
  logic [OW-1:0]             occ;
  logic                      job_done_q;
  logic [C_WEIGHT_WIDTH-1:0] mem [C_BUF_DEPTH];

  logic           in_load, stream_ready, beat_acc, burst_start, wren, burst_last;
  logic [PW-1:0]  push_n, push_cnt;
  logic [WLW-1:0] wl_init;
  logic [BLW-1:0] bl_init;

  always_comb begin
    in_load      = (state == S_LOAD);
    // Room for a whole beat is required, even if the final beat is partial.
    stream_ready = in_load && (beats_left != '0) &&
                   (occ <= OW'(C_BUF_DEPTH - C_WEIGHTS_PER_BEAT));
    beat_acc     = stream_ready && bus.wht_stream_valid;
    if (weights_left >= WLW'(C_WEIGHTS_PER_BEAT)) push_n = PW'(C_WEIGHTS_PER_BEAT);
    else                                          push_n = PW'(weights_left);
    push_cnt     = beat_acc ? push_n : '0;
    // A burst only starts once a whole kernel is buffered, so it can never underrun.
    burst_start  = in_load && !burst_act && (occ >= OW'(C_KERNEL_SIZE)) && (kernels_left != '0);
    wren         = in_load && (burst_act || burst_start);
    burst_last   = wren && (burst_cnt == BCW'(C_KERNEL_SIZE - 1));
    wl_init      = WLW'(C_KERNEL_SIZE) * WLW'(bus.job_num_kernels);
    bl_init      = BLW'((wl_init + WLW'(C_WEIGHTS_PER_BEAT - 1)) / WLW'(C_WEIGHTS_PER_BEAT));
  end

  always_comb begin
    state_nxt               = state;
    bus.job_ready           = 1'b0;
    bus.job_accept          = 1'b0;
    bus.kernel_config_valid = 1'b0;
    bus.config_mode         = 1'b0;
    case (state)
      S_IDLE: begin
        bus.job_ready = 1'b1;
        if (bus.job_start) state_nxt = (bus.job_num_kernels != '0) ? S_CFG : S_DONE;
      end
      S_CFG: begin
        bus.job_accept          = 1'b1;
        bus.kernel_config_valid = 1'b1;
        bus.config_mode         = 1'b1;
        state_nxt               = S_LOAD;
      end
      S_LOAD: begin
        bus.config_mode = 1'b1;
        if (burst_last && (kernels_left == KW'(1))) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.wht_stream_ready = stream_ready;
  assign bus.wht_config_wren  = wren;
  assign bus.wht_config_data  = wren ? mem[rp] : '0;
  assign bus.num_kernels      = num_kernels_q;
  assign bus.job_done         = job_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      kernels_left  <= '0;
      weights_left  <= '0;
      beats_left    <= '0;
      num_kernels_q <= '0;
      burst_act     <= 1'b0;
      burst_cnt     <= '0;
      wp            <= '0;
      rp            <= '0;
      occ           <= '0;
      job_done_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      // job_done trails the DONE state by one cycle.
      job_done_q <= (state == S_DONE);
      if ((state == S_IDLE) && bus.job_start && (bus.job_num_kernels != '0)) begin
        kernels_left  <= KW'(bus.job_num_kernels);
        weights_left  <= wl_init;
        beats_left    <= bl_init;
        num_kernels_q <= 16'(bus.job_num_kernels - 7'd1);
      end
      if (beat_acc) begin
        beats_left   <= beats_left - BLW'(1);
        weights_left <= weights_left - WLW'(push_n);
        wp           <= wp + AW'(push_n);
      end
      if (wren) rp <= rp + AW'(1);
      occ <= occ + OW'(push_cnt) - OW'(wren);
      if (burst_last) begin
        burst_act    <= 1'b0;
        burst_cnt    <= '0;
        kernels_left <= kernels_left - KW'(1);
      end else if (wren) begin
        burst_act <= 1'b1;
        burst_cnt <= burst_cnt + BCW'(1);
      end
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && beat_acc) begin
      for (int i = 0; i < C_WEIGHTS_PER_BEAT; i++) begin
        if (PW'(i) < push_n)
          mem[wp + AW'(i)] <= bus.wht_stream_data[i*C_WEIGHT_WIDTH +: C_WEIGHT_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_weight_loader.sv
module tb_cnn_layer_accel_weight_loader;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  cnn_layer_accel_weight_loader_if bus ();
  cnn_layer_accel_weight_loader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] beat_q[$];
  logic [15:0] exp_w[$];
  int          valid_mode = 0;   // 0: valid whenever data queued, 1: valid one cycle in three

  // Observations, owned by the monitor; cleared on request.
  logic [15:0] wq[$];
  int          wcyc[$], ja_cyc[$], kcv_cyc[$], done_cyc[$], acc_cyc[$], jr_cyc[$];
  int          rdy_cnt = 0;
  logic [15:0] nk_at_kcv = '0;
  int          clr_req = 0, clr_seen = 0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      wq.delete(); wcyc.delete(); ja_cyc.delete(); kcv_cyc.delete();
      done_cyc.delete(); acc_cyc.delete(); jr_cyc.delete(); rdy_cnt = 0;
    end
    if (bus.wht_config_wren) begin wq.push_back(bus.wht_config_data); wcyc.push_back(cyc); end
    if (bus.job_accept) ja_cyc.push_back(cyc);
    if (bus.kernel_config_valid) begin kcv_cyc.push_back(cyc); nk_at_kcv = bus.num_kernels; end
    if (bus.job_done) done_cyc.push_back(cyc);
    if (bus.wht_stream_valid && bus.wht_stream_ready) acc_cyc.push_back(cyc);
    if (bus.wht_stream_ready) rdy_cnt++;
    if (bus.job_ready) jr_cyc.push_back(cyc);
  end

  initial begin : stream_drv
    logic acc;
    int   phase;
    phase = 0;
    bus.wht_stream_valid = 1'b0;
    bus.wht_stream_data  = '0;
    forever begin
      @(negedge clk);
      acc = bus.wht_stream_valid && bus.wht_stream_ready;
      @(posedge clk); #1;
      if (acc && beat_q.size() > 0) void'(beat_q.pop_front());
      phase++;
      if (beat_q.size() > 0) begin
        bus.wht_stream_valid = (valid_mode == 0) || (phase % 3 == 0);
        bus.wht_stream_data  = beat_q[0];
      end else begin
        bus.wht_stream_valid = 1'b0;
        bus.wht_stream_data  = {$urandom, $urandom};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr_req++;
  endtask

  task automatic pulse_start(input int k, output int t);
    @(posedge clk); #1;
    bus.job_num_kernels = 7'(k);
    bus.job_start       = 1'b1;
    t                   = cyc;
    @(posedge clk); #1;
    bus.job_start = 1'b0;
  endtask

  // kind 0: random weights, kind 1: weight value = its index in the job
  task automatic load_beats(input int k, input int kind);
    int          nb;
    int          v;
    logic [63:0] beat;
    logic [15:0] w;
    nb = (9 * k + 3) / 4;
    v  = 0;
    beat_q.delete();
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < 4; l++) begin
        if (kind == 1) w = 16'(v);
        else           w = 16'($urandom);
        beat[l*16 +: 16] = w;
        v++;
      end
      beat_q.push_back(beat);
    end
  endtask

  // Reference: the job's weights are the first 9K lanes of the beat sequence, lane 0 first.
  task automatic build_expected(input int k);
    logic [63:0] beat;
    exp_w.delete();
    foreach (beat_q[b]) begin
      beat = beat_q[b];
      for (int l = 0; l < 4; l++)
        if (exp_w.size() < 9 * k) exp_w.push_back(beat[l*16 +: 16]);
    end
  endtask

  task automatic run_job(input int k, input int mode, input int stray_at, input string tag);
    int t, nb, d, lastw, busy_ready;
    nb = beat_q.size();
    build_expected(k);
    valid_mode = mode;
    clear_mon();
    pulse_start(k, t);
    for (int i = 0; i < 40 * k + 60 && done_cyc.size() == 0; i++) begin
      @(posedge clk); #1;
      bus.job_start = (stray_at != 0) && (cyc == t + stray_at);
      if (bus.job_start) bus.job_num_kernels = 7'd5;
    end
    bus.job_start = 1'b0;
    @(negedge clk);
    check({tag, "_cfgmode_after"}, bus.config_mode, 0);
    check({tag, "_ready_after"}, bus.job_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cyc.size(), 1);
    d     = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    lastw = (wcyc.size() > 0) ? wcyc[wcyc.size()-1] : -1;
    check({tag, "_nwrites"}, wq.size(), 9 * k);
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) check({tag, "_wdata"}, wq[i], exp_w[i]);
    for (int kk = 0; kk < k; kk++)
      if (wcyc.size() >= 9 * kk + 9) check({tag, "_burst_span"}, wcyc[9*kk+8] - wcyc[9*kk], 8);
    check({tag, "_ja_count"}, ja_cyc.size(), 1);
    check({tag, "_ja_cycle"}, (ja_cyc.size() > 0) ? ja_cyc[0] : -1, t + 1);
    check({tag, "_kcv_cycle"}, (kcv_cyc.size() > 0) ? kcv_cyc[0] : -1, t + 1);
    check({tag, "_num_kernels"}, nk_at_kcv, k - 1);
    check({tag, "_beats_acc"}, acc_cyc.size(), nb);
    check({tag, "_stream_left"}, beat_q.size(), 0);
    busy_ready = 0;
    foreach (jr_cyc[i]) if (jr_cyc[i] > t && jr_cyc[i] < d) busy_ready++;
    check({tag, "_ready_busy"}, busy_ready, 0);
    if (mode == 0) begin
      check({tag, "_first_wren"}, (wcyc.size() > 0) ? wcyc[0] : -1, t + 5);
      check({tag, "_last_wren"}, lastw, t + 4 + 9 * k);
      check({tag, "_done_cycle"}, d, t + 6 + 9 * k);
      for (int i = 0; i < 3 && i < acc_cyc.size(); i++) check({tag, "_beat_cycle"}, acc_cyc[i], t + 2 + i);
      check({tag, "_ready_cycles"}, rdy_cnt, nb);
    end else begin
      check({tag, "_done_after_last"}, d, lastw + 2);
    end
  endtask

  initial begin : main
    int t, k, m;
    rst = 1'b1;
    bus.job_start = 1'b0;
    bus.job_num_kernels = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", bus.job_ready, 1);
    check("rst_job_done", bus.job_done, 0);
    check("rst_config_mode", bus.config_mode, 0);
    check("rst_job_accept", bus.job_accept, 0);
    check("rst_kcv", bus.kernel_config_valid, 0);
    check("rst_num_kernels", bus.num_kernels, 0);
    check("rst_wren", bus.wht_config_wren, 0);
    check("rst_wdata", bus.wht_config_data, 0);
    check("rst_stream_ready", bus.wht_stream_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single kernel, last beat mostly discarded.
    beat_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, 64'hDEAD_BEEF_CAFE_0009};
    run_job(1, 0, 0, "k1");

    // Largest job, weights 0..575 in order.
    load_beats(64, 1);
    run_job(64, 0, 0, "k64");

    // Stream valid one cycle in three.
    load_beats(3, 0);
    run_job(3, 1, 0, "k3_stall");

    for (int j = 0; j < 4; j++) begin
      k = $urandom_range(1, 12);
      m = $urandom_range(0, 1);
      load_beats(k, 0);
      run_job(k, m, 0, "rand");
    end

    // A second job_start during LOAD must be ignored.
    load_beats(2, 0);
    run_job(2, 0, 7, "k2_stray");
    check("stray_num_kernels_held", bus.num_kernels, 1);

    // Reset on the 4th write of kernel 0.
    load_beats(2, 0);
    valid_mode = 0;
    clear_mon();
    pulse_start(2, t);
    for (int i = 0; i < 60 && wq.size() < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_wait", wq.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_4th_wren", bus.wht_config_wren, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete();
    @(negedge clk);
    check("rst_mid_wren", bus.wht_config_wren, 0);
    check("rst_mid_config_mode", bus.config_mode, 0);
    check("rst_mid_job_ready", bus.job_ready, 1);
    check("rst_mid_stream_ready", bus.wht_stream_ready, 0);
    repeat (2) @(posedge clk);
    load_beats(1, 0);
    run_job(1, 0, 0, "k1_after_rst");

    // Zero-kernel job.
    clear_mon();
    pulse_start(0, t);
    for (int i = 0; i < 20 && done_cyc.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("k0_done_cycle", (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 2);
    check("k0_done_pulses", done_cyc.size(), 1);
    check("k0_job_accept", ja_cyc.size(), 0);
    check("k0_kcv", kcv_cyc.size(), 0);
    check("k0_writes", wq.size(), 0);
    check("k0_stream_ready", rdy_cnt, 0);
    check("k0_num_kernels_held", bus.num_kernels, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_weight_loader.md
Name: cnn_layer_accel_weight_loader

Overview:
Feeds the weight table's configuration port for one CNN job. It takes a job descriptor (kernel count) and a 64-bit weight stream from the DMA side, and unpacks the stream into 16-bit weights. It then issues the table's configuration handshake: a job_accept pulse, kernel_config_valid with num_kernels, config_mode, and wht_config_wren/wht_config_data writes. Each 3x3 kernel's 9 weights are written as one uninterrupted burst of 9 consecutive cycles, because the table's kernel counter wraps unconditionally after index 8.

Parameters:
C_WEIGHT_WIDTH, 16, width of one weight; equals table write width.
C_WEIGHTS_PER_BEAT, 4, weights packed per stream beat; lane 0 = bits[15:0] is consumed first.
C_KERNEL_SIZE, 9, weights per kernel (3x3).
C_MAX_KERNELS, 64, maximum kernels per job; the table's kernel_group is 6 bits.
C_BUF_DEPTH, 16, depth in weights of the internal unpack FIFO; must be >= C_KERNEL_SIZE + C_WEIGHTS_PER_BEAT - 1.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
job_start  in  1  single-cycle request to load one job's weights
job_num_kernels  in  7  kernels in the job, 1..64; sampled with job_start
job_ready  out  1  high only in IDLE
job_done  out  1  single-cycle pulse when the job's loading is complete
wht_stream_data  in  64  packed weights
wht_stream_valid  in  1  stream beat valid
wht_stream_ready  out  1  beat accepted when valid && ready
config_mode  out  1  table in configuration mode
job_accept  out  1  single-cycle pulse; clears the table's kernel_count and kernel_group
kernel_config_valid  out  1  single-cycle pulse; qualifies num_kernels
num_kernels  out  16  job_num_kernels - 1 (index of last kernel group), zero-extended; held until the next job
wht_config_wren  out  1  weight write strobe
wht_config_data  out  16  weight value; valid with wren

Behaviour:
- Reset values: all outputs 0, except job_ready = 1. State IDLE, FIFO empty, all counters 0.
- States: IDLE, CFG, LOAD, DONE.
- IDLE: on job_start with job_num_kernels != 0:
  - latch K = job_num_kernels;
  - weights_left = 9*K (10-bit);
  - beats_left = ceil(9K/4) (8-bit);
  - next state CFG.
- IDLE, job_start with job_num_kernels == 0: go to DONE; no job_accept, no kernel_config_valid, no writes.
- job_start outside IDLE is ignored.
- CFG (1 cycle): job_accept = 1, kernel_config_valid = 1, config_mode = 1, num_kernels = K-1. Next state LOAD.
- LOAD: config_mode = 1.
  - wht_stream_ready = (beats_left != 0) && (fifo_occ <= C_BUF_DEPTH - C_WEIGHTS_PER_BEAT).
  - On an accepted beat, push min(4, weights_to_fetch) lanes in lane order and discard the rest. Only the final beat of a job may be partial, e.g. K=1 pushes 4, 4, then 1 weight.
  - Burst start condition: no burst active, fifo_occ >= 9 (occupancy registered at the previous clock edge), and kernels_left != 0.
  - A burst asserts wht_config_wren for exactly 9 consecutive cycles, popping one weight per cycle onto wht_config_data.
  - A burst is never interrupted, including by stream stalls.
  - Bursts are back-to-back when the FIFO holds enough data.
  - Push and pop in the same cycle: fifo_occ += pushed - popped.
- LOAD -> DONE in the cycle after the 9th write of the last kernel.
  - config_mode stays 1 through that write cycle, so the table's group increment qualifies.
  - config_mode drops to 0 on entering DONE.
- DONE (1 cycle): job_done = 1, then IDLE.
- Latency with the stream always valid: job_start at cycle t gives:
  - CFG at t+1;
  - wht_stream_ready from t+2;
  - beats accepted at t+2, t+3, t+4;
  - first wren at t+5;
  - a K-kernel job's last wren at t+4+9K (the stream outpaces the writes), job_done at t+6+9K.
- Arithmetic: counters are sized for the maximum (9*64 = 576 weights, 144 beats) and never wrap within a job. The FIFO read/write pointers wrap modulo C_BUF_DEPTH.
- rst mid-job: immediate return to IDLE, FIFO flushed, every strobe deasserted next cycle. Partially written table contents are left as-is; the next job_accept clears the table's counters.

Test Plan:
- K=1; beats 0x0004_0003_0002_0001, 0x0008_0007_0006_0005, 0xDEAD_BEEF_CAFE_0009 -> num_kernels=0, writes 1..9 on 9 consecutive cycles, upper 3 lanes of beat 3 discarded, job_done at t+15, config_mode low afterward.
- K=64, 144 beats with values 0..575, valid always high -> 64 bursts of 9 with no wren gap, data equals 0..575 in order, num_kernels=63, beats_left reaches 0 exactly at the 144th beat.
- K=3 with wht_stream_valid toggling 1-of-3 cycles -> every wren burst is exactly 9 contiguous cycles, no FIFO overflow (ready drops at occupancy >12), 27 writes total.
- job_start asserted again during LOAD with job_num_kernels=5 -> ignored; the running K=2 job completes with 18 writes; job_ready=0 until after job_done.
- rst asserted on the 4th write of kernel 0 -> next cycle wren=0, config_mode=0, job_ready=1; a subsequent K=1 job runs cleanly from job_accept.
- job_start with job_num_kernels=0 -> job_done at t+2, no job_accept, no kernel_config_valid, no wren, wht_stream_ready never asserted.
